// File: rtl/axi_burst_pkg.sv
// ============================================================================
// Module   : axi_burst_pkg
// Brief    : Shared types and constants for the AXI burst address generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axi_burst_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam int PAGE_4K_BITS = 12;

endpackage

`default_nettype wire

// File: rtl/axi_burst_next_addr.sv
// ============================================================================
// Module   : axi_burst_next_addr
// Brief    : Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_burst_next_addr
  import axi_burst_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int LEN_WIDTH      = 8,
  parameter int SIZE_WIDTH     = 3
) (
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  input  logic [LEN_WIDTH-1:0]      i_len,
  input  logic [SIZE_WIDTH-1:0]     i_size,
  input  burst_t                    i_burst,
  output logic [AXI_ADDR_WIDTH-1:0] o_next_addr
);

  logic [AXI_ADDR_WIDTH-1:0] w_step;
  logic [AXI_ADDR_WIDTH-1:0] w_incr;
  logic [AXI_ADDR_WIDTH-1:0] w_mask;

  assign w_step = AXI_ADDR_WIDTH'(1) << i_size;
  assign w_incr = i_addr + w_step;
  // Wrap window spans (len+1) beats of 2^size bytes each.
  assign w_mask = ((AXI_ADDR_WIDTH'(i_len) + AXI_ADDR_WIDTH'(1)) << i_size) - AXI_ADDR_WIDTH'(1);

  always_comb begin
    o_next_addr = w_incr;
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
      default:     o_next_addr = w_incr;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
// ============================================================================
// Module   : axi_burst_addr_gen
// Brief    : Per-beat AXI burst address generator with valid/ready handshake.
//            Optional 4 KiB page-crossing check: AXI_BURST_4K_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int LEN_WIDTH      = 8,
  parameter int SIZE_WIDTH     = 3
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      run,
  input  logic                      i_start,
  input  logic [AXI_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]      i_len,
  input  logic [SIZE_WIDTH-1:0]     i_size,
  input  logic [1:0]                i_burst,
  input  logic                      i_ready,
  output logic [AXI_ADDR_WIDTH-1:0] o_addr,
  output logic                      o_valid,
  output logic                      o_last,
  output logic                      o_busy,
  output logic                      o_done,
`ifdef AXI_BURST_4K_CHECK_EN
  output logic                      o_cross4k,
`endif
  output logic                      o_err
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]      r_len;
  logic [SIZE_WIDTH-1:0]     r_size;
  burst_t                    r_burst;
  logic [LEN_WIDTH-1:0]      r_cnt;
  logic                      r_done;
  logic                      r_err;

  logic [AXI_ADDR_WIDTH-1:0] w_next_addr;
  logic [AXI_ADDR_WIDTH-1:0] w_step;
  logic                      w_misalign;
  logic                      w_wrap_len_ok;
  logic                      w_illegal;
  logic                      w_err_start;
  logic                      w_accept;
  logic                      w_hs;
  logic                      w_clear;

  assign w_clear  = !arst_n || !run;
  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_hs     = o_valid && i_ready;

  assign w_step        = AXI_ADDR_WIDTH'(1) << i_size;
  assign w_misalign    = |(i_base_addr & (w_step - AXI_ADDR_WIDTH'(1)));
  assign w_wrap_len_ok = (i_len == LEN_WIDTH'(1)) || (i_len == LEN_WIDTH'(3)) ||
                         (i_len == LEN_WIDTH'(7)) || (i_len == LEN_WIDTH'(15));
  assign w_illegal     = (i_burst == BURST_RSVD) ||
                         ((i_burst == BURST_WRAP) && (!w_wrap_len_ok || w_misalign));

`ifdef AXI_BURST_4K_CHECK_EN
  logic                      r_cross4k;
  logic [AXI_ADDR_WIDTH-1:0] w_final_addr;
  logic                      w_cross4k;

  // Illegal requests run as INCR, so they are subject to the page check too.
  assign w_final_addr = i_base_addr + (AXI_ADDR_WIDTH'(i_len) << i_size);
  assign w_cross4k    = (w_illegal || (i_burst == BURST_INCR)) &&
                        (w_final_addr[AXI_ADDR_WIDTH-1:PAGE_4K_BITS] !=
                         i_base_addr[AXI_ADDR_WIDTH-1:PAGE_4K_BITS]);
  assign w_err_start  = w_illegal || w_cross4k;
  assign o_cross4k    = r_cross4k;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_cross4k <= 1'b0;
    end else if (w_accept) begin
      r_cross4k <= w_cross4k;
    end
  end
`else
  assign w_err_start = w_illegal;
`endif

  axi_burst_next_addr #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .LEN_WIDTH      (LEN_WIDTH),
    .SIZE_WIDTH     (SIZE_WIDTH)
  ) u_next_addr (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_hs && (r_cnt == '0)) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= BURST_FIXED;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_addr  <= i_base_addr;
        r_len   <= i_len;
        r_size  <= i_size;
        r_burst <= w_illegal ? BURST_INCR : burst_t'(i_burst);
        r_cnt   <= i_len;
        r_err   <= w_err_start;
      end else if (w_hs) begin
        if (r_cnt == '0) begin
          r_done <= 1'b1;
        end else begin
          r_cnt  <= r_cnt - LEN_WIDTH'(1);
          r_addr <= w_next_addr;
        end
      end
    end
  end

  assign o_addr  = r_addr;
  assign o_valid = (r_state == ST_ACTIVE);
  assign o_busy  = (r_state == ST_ACTIVE);
  assign o_last  = (r_cnt == '0) && o_valid;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule

`default_nettype wire
